counter_sync_down: RTL

COUNTER_SYNC_DOWN -- requirements
Module: counter_sync_down

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_reload_reg.sv | 28 ++
 rtl/counter_sync_down.sv | 91 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the synchronous down-counter.
// Holds the three-state FSM encoding and the legal WIDTH bounds.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

endpackage

// File: rtl/counter_reload_reg.sv
// Reload register for the down-counter.
// It captures the start value on every load, so a reload always restarts from the last loaded value.
module counter_reload_reg import counter_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             capture_i,
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] value_q;

  // Reload value storage, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else if (capture_i) begin
      value_q <= value_i;
    end else begin
      value_q <= value_q;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/counter_sync_down.sv
// Loadable synchronous down-counter with IDLE/RUN/DONE control, optional auto-reload
// and a registered one-cycle terminal-count pulse.
module counter_sync_down import counter_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] out,
  output logic             tc_pulse,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] reload_q;

  counter_reload_reg #(.WIDTH(WIDTH)) u_reload (
    .clk_i     (clock),
    .rst_ni    (reset),
    .capture_i (load),
    .value_i   (load_val),
    .value_o   (reload_q)
  );

  // State, count and terminal pulse registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      tc_q    <= tc_d;
    end
  end

  // Next-state logic: load beats any terminal event, so a colliding load never pulses
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    tc_d    = 1'b0;
    if (load) begin
      out_d   = load_val;
      state_d = (load_val != '0) ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (enable) begin
            if (out_q == WIDTH'(1)) begin
              tc_d = 1'b1;
              if (auto_reload) begin
                out_d = reload_q;
              end else begin
                out_d   = '0;
                state_d = ST_DONE;
              end
            end else begin
              out_d = out_q - WIDTH'(1);
            end
          end else begin
            out_d = out_q;
          end
        end
        ST_IDLE, ST_DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
          out_d   = '0;
        end
      endcase
    end
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  assign out      = out_q;
  assign tc_pulse = tc_q;

endmodule
